// File: rtl/dmem_wait_pkg.sv
// Shared pipeline constants for the wait-state data memory: FSM state encodings and default latency.
package dmem_wait_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WAIT_DEFAULT = 2;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_wait_array.sv
// Word-addressed data storage: synchronous write, asynchronous read, contents survive reset.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_wait.sv
// M-stage data memory with a fixed number of stall cycles per access and a saturating stall counter.
//
// state | meaning
// IDLE  | no access in flight; a request is accepted and stalls this cycle
// BUSY  | remaining wait cycles, cnt counts down to zero
// DONE  | result cycle: ReadDataM/ErrM valid, stall released, store commits on exit
module dmem_wait
    import dmem_wait_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = WAIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        DEnM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ErrM,
    output logic [15:0] StallCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT >= 2) ? 4'(WAIT - 2) : 4'd0;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [15:0]   stall_cnt_q;
    logic          stall;

    logic [AW+1:0] addr_eff;
    logic          we_eff;
    logic          mis_eff;
    logic          enter_done;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    logic unused_addr_hi;
    assign unused_addr_hi = ^ALUOutM[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (DEnM) begin
                    stall   = 1'b1;
                    addr_d  = ALUOutM[AW+1:0];
                    wdata_d = WriteDataM;
                    we_d    = MemWriteM;
                    if (WAIT == 1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With WAIT=1 the result edge is also the accept edge, so read from the live inputs.
    assign addr_eff   = (state_q == IDLE) ? ALUOutM[AW+1:0] : addr_q;
    assign we_eff     = (state_q == IDLE) ? MemWriteM : we_q;
    assign mis_eff    = is_misaligned(addr_eff[1:0]);
    assign enter_done = (state_d == DONE) && (state_q != DONE);

    // Store commits on the edge leaving DONE; a reset on that edge discards it.
    assign mem_we = Reset && (state_q == DONE) && we_q && !is_misaligned(addr_q[1:0]);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= enter_done && mis_eff;
            if (enter_done) begin
                if (mis_eff) begin
                    rdata_q <= 32'd0;
                end else if (!we_eff) begin
                    rdata_q <= mem_rdata;
                end
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .CLK     (CLK),
        .we_i    (mem_we),
        .waddr_i (addr_q[AW+1:2]),
        .wdata_i (wdata_q),
        .raddr_i (addr_eff[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    assign ReadDataM = rdata_q;
    assign StallM    = stall;
    assign ErrM      = err_q;
    assign StallCnt  = stall_cnt_q;

endmodule

// File: doc/dmem_wait.md
DMEM_WAIT -- requirements
Module: dmem_wait

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the data array; power of two.
REQ-002 Parameter WAIT, default 2, stall cycles per access; legal range 1..15.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 DEnM  input  1  M-stage data-memory access request from the pipeline controller.
REQ-006 MemWriteM  input  1  1 = store, 0 = load; meaningful only with DEnM=1.
REQ-007 ALUOutM  input  32  byte address of the access.
REQ-008 WriteDataM  input  32  store data.
REQ-009 ReadDataM  output  32  registered load data.
REQ-010 StallM  output  1  freeze request to the hazard unit; holds F/D/E/M while 1.
REQ-011 ErrM  output  1  misaligned-access flag, valid in DONE cycle.
REQ-012 StallCnt  output  16  saturating count of cycles StallM was 1.

Function
REQ-013 States IDLE, BUSY, DONE; a counter cnt of 4 bits.
REQ-014 IDLE with DEnM=0: StallM=0, remain IDLE.
REQ-015 IDLE with DEnM=1: StallM=1 combinationally in that cycle; latch address, write data, MemWriteM; WAIT=1 -> DONE, else cnt=WAIT-2, -> BUSY.
REQ-016 BUSY: StallM=1; cnt=0 -> DONE, else cnt decrements.
REQ-017 DONE: StallM=0, ErrM and ReadDataM valid; always -> IDLE next cycle.
REQ-018 Total StallM=1 cycles per access is exactly WAIT; pipeline advances at the end of the DONE cycle.
REQ-019 Inputs are ignored in BUSY and DONE; only the values latched on acceptance are used.
REQ-020 Back-to-back accesses: a new request is accepted only in IDLE, so the minimum access spacing is WAIT+1 cycles.
REQ-021 Word index = latched address[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH words.
REQ-022 Misaligned access (latched address[1:0] != 0): ErrM=1 in DONE; ReadDataM loads 0; the store is suppressed.
REQ-023 Load: ReadDataM loads the array word on the edge entering DONE and holds that value until the next load completes.
REQ-024 Store: the array word is written on the edge leaving DONE; ReadDataM is unchanged by a store.
REQ-025 ErrM=0 in all states other than DONE.
REQ-026 StallCnt increments on every edge where StallM=1; it saturates at 16'hFFFF.

Reset
REQ-027 Reset=0 at an edge: state IDLE, cnt=0, ReadDataM=0, ErrM=0, StallCnt=0; StallM is 0 the following cycle.
REQ-028 Reset during BUSY or DONE aborts the access; a pending store is discarded.
REQ-029 Array contents are not cleared by reset.

Structure
REQ-030 State encodings (IDLE=2'b00, BUSY=2'b01, DONE=2'b10) and the WAIT default live in the shared MIPS pipeline constants package/header.
REQ-031 The storage is a single sub-module dmem_array: DEPTH x 32, synchronous write, asynchronous read.
REQ-032 The FSM, latches and StallCnt reside in dmem_wait; target size is 120-250 lines total.

Verification
REQ-033 Store: WAIT=2, store 32'hDEADBEEF to address 0x10 -> StallM=1 for 2 cycles, then DONE; a later load from 0x10 returns 32'hDEADBEEF, StallCnt=4.
REQ-034 WAIT=1, load from 0x0 after reset -> StallM=1 for 1 cycle, ReadDataM valid on the next cycle, ErrM=0.
REQ-035 Misaligned store to 0x13 -> ErrM=1 in DONE; word 0x10 is unchanged; ReadDataM=0.
REQ-036 DEPTH=256, store 32'h1 to 0x400 -> a load from 0x0 returns 32'h1 (wrap).
REQ-037 Reset=0 during BUSY of a store of 32'hA5A5A5A5 to 0x20 -> next cycle IDLE, StallM=0, StallCnt=0; a load from 0x20 returns the old value.
REQ-038 DEnM held at 1 continuously with WAIT=3 -> StallM pattern 1,1,1,0 repeats; each access completes exactly once.
